// File: rtl/fullchip_drain_pkg.sv
// ---------------------------------------------------------------------------
// fullchip_drain_pkg
// Shared definitions for the chip-level psum output stage:
//   - MODE_RAW / MODE_SUM : encodings of the per-vector mode bit
//   - drain_state_e       : drain FSM states
//   - nbeats()            : number of output beats per vector for a mode
// ---------------------------------------------------------------------------
package fullchip_drain_pkg;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_SUM = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_e;

  // Raw mode ships every core's columns; sum mode ships one column set.
  function automatic int nbeats(input logic mode, input int n_core,
                                input int n_col, input int n_lanes);
    return (mode == MODE_SUM) ? (n_col / n_lanes) : (n_core * n_col / n_lanes);
  endfunction

endpackage

// File: rtl/psum_lane_sum.sv
// ---------------------------------------------------------------------------
// psum_lane_sum
// Combinational signed sum of one column across all cores.
//   i_psums : ncore signed psums, core c at [c*bw_psum +: bw_psum]
//   o_sum   : signed sum at full bw_sum width (cannot overflow)
// ---------------------------------------------------------------------------
module psum_lane_sum #(
  parameter int ncore   = 2,
  parameter int bw_psum = 11,
  parameter int bw_sum  = 12
) (
  input  logic [ncore*bw_psum-1:0] i_psums,
  output logic [bw_sum-1:0]        o_sum
);

  logic signed [bw_sum-1:0] w_acc;

  always_comb begin
    // NOTE: blocking is right here: w_acc is a combinational running total
    // rebuilt from zero on every evaluation, not a stored value.
    w_acc = '0;
    for (int c = 0; c < ncore; c++) begin
      w_acc = w_acc + bw_sum'(signed'(i_psums[c*bw_psum +: bw_psum]));
    end
    o_sum = w_acc;
  end

endmodule

// File: rtl/fullchip_drain.sv
// ---------------------------------------------------------------------------
// fullchip_drain
// Captures one psum vector per handshake into a ping-pong buffer and drains
// it off-chip as lanes-wide beats. Raw mode sends every core's words; sum
// mode adds the cores per column first. Capture overlaps drain.
// Ports:
//   clk, reset (async, active-low)
//   in_valid / in_ready / in_data / mode : vector input, mode sampled with it
//   out_valid / out_ready / out_data / out_last : beat output
//   ovf : sticky, set when a vector arrives while no bank is free
// ---------------------------------------------------------------------------
module fullchip_drain
  import fullchip_drain_pkg::*;
#(
  parameter  int col     = 8,
  parameter  int bw_psum = 11,
  parameter  int ncore   = 2,
  parameter  int lanes   = 2,
  localparam int bw_sum  = bw_psum + $clog2(ncore)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ncore*col*bw_psum-1:0] in_data,
  input  logic                         mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [lanes*bw_sum-1:0]      out_data,
  output logic                         out_last,
  output logic                         ovf
);

  localparam int VEC_W  = ncore * col * bw_psum;
  localparam int MAX_NB = ncore * col / lanes;
  localparam int BEAT_W = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;

  logic [VEC_W-1:0]        r_bank_data [2];
  logic                    r_bank_mode [2];
  logic [1:0]              r_full;
  logic                    r_wp;
  logic                    r_rp;
  logic [BEAT_W-1:0]       r_beat;
  drain_state_e            r_state;
  drain_state_e            w_state_next;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [lanes*bw_sum-1:0] r_out_data;
  logic                    r_ovf;

  logic                    w_capture;
  logic                    w_beat_avail;
  logic                    w_load;
  logic                    w_last_beat;
  logic                    w_free;
  logic [VEC_W-1:0]        w_rd_data;
  logic                    w_rd_mode;
  int                      w_beat_base;
  logic [bw_psum-1:0]      w_raw_word   [lanes];
  logic [ncore*bw_psum-1:0] w_lane_psums [lanes];
  logic [bw_sum-1:0]       w_lane_sum   [lanes];
  logic [lanes*bw_sum-1:0] w_beat_data;

  assign in_ready  = ~r_full[r_wp];
  assign w_capture = in_valid & ~r_full[r_wp];

  assign w_rd_data = r_bank_data[r_rp];
  assign w_rd_mode = r_bank_mode[r_rp];

  // A beat can be produced whenever the read bank holds a vector; in SEND the
  // read bank is full by construction.
  assign w_beat_avail = (r_state == ST_SEND) | r_full[r_rp];
  assign w_load       = w_beat_avail & (~r_out_valid | out_ready);
  assign w_last_beat  = (int'(r_beat) == nbeats(w_rd_mode, ncore, col, lanes) - 1);
  assign w_free       = w_load & w_last_beat;

  // NOTE: payload flops carry no reset; the full flags decide whether their
  // contents mean anything, so clearing them would only cost reset routing.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_bank_data[r_wp] <= in_data;
      r_bank_mode[r_wp] <= mode;
    end
  end

  // Column / word selection for the current beat.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_beat_base = int'(r_beat) * lanes;
    for (int l = 0; l < lanes; l++) begin
      w_raw_word[l]   = '0;
      w_lane_psums[l] = '0;
      for (int w = 0; w < ncore * col; w++) begin
        if (w == w_beat_base + l) w_raw_word[l] = w_rd_data[w*bw_psum +: bw_psum];
      end
      for (int c = 0; c < ncore; c++) begin
        for (int j = 0; j < col; j++) begin
          if (j == w_beat_base + l)
            w_lane_psums[l][c*bw_psum +: bw_psum] = w_rd_data[(c*col+j)*bw_psum +: bw_psum];
        end
      end
    end
  end

  for (genvar g = 0; g < lanes; g++) begin : g_lane
    psum_lane_sum #(
      .ncore   (ncore),
      .bw_psum (bw_psum),
      .bw_sum  (bw_sum)
    ) u_sum (
      .i_psums (w_lane_psums[g]),
      .o_sum   (w_lane_sum[g])
    );
  end

  always_comb begin
    w_beat_data = '0;
    for (int l = 0; l < lanes; l++) begin
      w_beat_data[l*bw_sum +: bw_sum] = (w_rd_mode == MODE_SUM)
        ? w_lane_sum[l]
        : bw_sum'(signed'(w_raw_word[l]));
    end
  end

  // Drain FSM next state. Leaving SEND checks the other bank as registered;
  // a capture landing on the same edge is picked up from IDLE one cycle
  // later, which still loads its beat 0 without a bubble.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rp]) w_state_next = (w_free & ~r_full[~r_rp]) ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (w_free & ~r_full[~r_rp]) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: all registered state uses non-blocking assignment so every
  // statement here sees pre-edge values regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full      <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      // Capture and free always touch different banks.
      if (w_capture) begin
        r_full[r_wp] <= 1'b1;
        r_wp         <= ~r_wp;
      end
      if (in_valid && r_full[r_wp]) r_ovf <= 1'b1;
      if (w_free) begin
        r_full[r_rp] <= 1'b0;
        r_rp         <= ~r_rp;
      end
      if (w_load) begin
        r_beat      <= w_last_beat ? '0 : r_beat + 1'b1;
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat_data;
        r_out_last  <= w_last_beat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fullchip_drain.sv
// ---------------------------------------------------------------------------
// tb_fullchip_drain
// Scoreboard bench for fullchip_drain (col=8, bw_psum=11, ncore=2, lanes=2).
// Expected beats are pushed when a vector is handed over and popped by a
// monitor whenever a beat is accepted.
// ---------------------------------------------------------------------------
module tb_fullchip_drain;

  localparam int COL     = 8;
  localparam int BW_PSUM = 11;
  localparam int NCORE   = 2;
  localparam int LANES   = 2;
  localparam int BW_SUM  = 12;
  localparam int VEC_W   = NCORE * COL * BW_PSUM;
  localparam int OUT_W   = LANES * BW_SUM;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_data;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             ovf;

  logic [OUT_W:0]   exp_q [$];
  logic [OUT_W:0]   mon_exp;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_beats  = 0;

  always #5 clk = ~clk;

  fullchip_drain #(
    .col     (COL),
    .bw_psum (BW_PSUM),
    .ncore   (NCORE),
    .lanes   (LANES)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, actual still running, required finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [BW_SUM-1:0] sext(input logic [BW_PSUM-1:0] w);
    return {w[BW_PSUM-1], w};
  endfunction

  function automatic int nb_of(input logic m);
    return m ? COL / LANES : NCORE * COL / LANES;
  endfunction

  task automatic push_expected(input logic [VEC_W-1:0] v, input logic m);
    int nb;
    int idx;
    logic [OUT_W-1:0] d;
    nb = nb_of(m);
    for (int k = 0; k < nb; k++) begin
      d = '0;
      for (int l = 0; l < LANES; l++) begin
        idx = k * LANES + l;
        if (!m) d[l*BW_SUM +: BW_SUM] = sext(v[idx*BW_PSUM +: BW_PSUM]);
        else    d[l*BW_SUM +: BW_SUM] = sext(v[idx*BW_PSUM +: BW_PSUM])
                                      + sext(v[(COL+idx)*BW_PSUM +: BW_PSUM]);
      end
      exp_q.push_back({(k == nb - 1), d});
    end
  endtask

  function automatic logic [VEC_W-1:0] vec_ramp();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int j = 0; j < COL; j++) begin
      v[j*BW_PSUM +: BW_PSUM]       = BW_PSUM'(j);
      v[(COL+j)*BW_PSUM +: BW_PSUM] = BW_PSUM'(-(j + 1));
    end
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] vec_fill(input logic [BW_PSUM-1:0] x);
    logic [VEC_W-1:0] v;
    for (int w = 0; w < NCORE * COL; w++) v[w*BW_PSUM +: BW_PSUM] = x;
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] vec_rand();
    logic [VEC_W-1:0] v;
    for (int w = 0; w < NCORE * COL; w++) v[w*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_beats++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: actual beat data=%h last=%b, required no beat",
                 out_data, out_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_last, out_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard_beat: actual data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, mon_exp[OUT_W-1:0], mon_exp[OUT_W]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Inputs change 1 time unit after the rising edge; vectors are offered only
  // while in_ready is high so nothing is dropped unintentionally.
  task automatic send_vec(input logic [VEC_W-1:0] v, input logic m);
    int waited;
    waited = 0;
    while (!in_ready && waited < 500) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_vec_timeout: actual in_ready=%b, required 1", in_ready);
    end else begin
      in_valid = 1'b1;
      in_data  = v;
      mode     = m;
      push_expected(v, m);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < max_cycles) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int valid_seen;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: actual %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: actual %b, required 0", out_valid); end
    if (out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last: actual %b, required 0", out_last); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: actual %h, required 0", out_data); end
    if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf: actual %b, required 0", ovf); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while beat 3 of a raw vector is on the output.
    out_ready = 1'b1;
    send_vec(vec_ramp(), 1'b0);
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_drain_valid: actual %b, required 1", out_valid); end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: actual %b, required 0", out_valid); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL async_reset_data: actual %h, required 0", out_data); end
    if (out_last !== 1'b0)  begin n_fail++; $display("FAIL async_reset_last: actual %b, required 0", out_last); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL async_reset_in_ready: actual %b, required 1", in_ready); end
    if (ovf !== 1'b0)       begin n_fail++; $display("FAIL async_reset_ovf: actual %b, required 0", ovf); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    valid_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) valid_seen++;
    end
    n_checks++;
    if (valid_seen !== 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: actual %0d valid cycles, required 0", valid_seen);
    end
  endtask

  task automatic test_raw();
    int b0;
    b0 = n_beats;
    out_ready = 1'b1;
    send_vec(vec_ramp(), 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_latency_early: actual %b, required 0", out_valid); end
    @(posedge clk); #1;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_latency: actual %b, required 1", out_valid); end
    if (out_data !== {12'h001, 12'h000}) begin
      n_fail++; $display("FAIL raw_beat0: actual %h, required %h", out_data, {12'h001, 12'h000});
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== {12'hFFE, 12'hFFF}) begin
      n_fail++; $display("FAIL raw_beat4: actual %h, required %h", out_data, {12'hFFE, 12'hFFF});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_last !== 1'b1) begin n_fail++; $display("FAIL raw_last_beat7: actual %b, required 1", out_last); end
    wait_drain(200);
    n_checks++;
    if (n_beats - b0 !== 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL raw_beat_count: actual %0d, required 8", n_beats - b0);
    end
  endtask

  task automatic test_sum_extremes();
    int b0;
    out_ready = 1'b1;
    b0 = n_beats;
    send_vec(vec_fill(11'h400), 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (out_data !== {12'h800, 12'h800}) begin
      n_fail++; $display("FAIL sum_min: actual %h, required %h", out_data, {12'h800, 12'h800});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_last !== 1'b1) begin n_fail++; $display("FAIL sum_last_beat3: actual %b, required 1", out_last); end
    wait_drain(200);
    n_checks++;
    if (n_beats - b0 !== 4) begin n_fail++; $display("FAIL sum_min_count: actual %0d, required 4", n_beats - b0); end

    b0 = n_beats;
    send_vec(vec_fill(11'h3FF), 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (out_data !== {12'h7FE, 12'h7FE}) begin
      n_fail++; $display("FAIL sum_max: actual %h, required %h", out_data, {12'h7FE, 12'h7FE});
    end
    wait_drain(200);
    n_checks++;
    if (n_beats - b0 !== 4) begin n_fail++; $display("FAIL sum_max_count: actual %0d, required 4", n_beats - b0); end
  endtask

  task automatic test_streaming();
    int seen;
    int gaps;
    int cyc;
    bit started;
    seen = 0; gaps = 0; cyc = 0; started = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send_vec(vec_rand(), 1'(i % 2));
      end
      begin
        while (seen < 36 && cyc < 2000) begin
          @(posedge clk); #2;
          cyc++;
          if (out_valid) begin started = 1'b1; seen++; end
          else if (started) gaps++;
        end
      end
    join
    wait_drain(200);
    n_checks += 3;
    if (seen !== 36)        begin n_fail++; $display("FAIL stream_beats: actual %0d, required 36", seen); end
    if (gaps !== 0)         begin n_fail++; $display("FAIL stream_gapless: actual %0d gaps, required 0", gaps); end
    if (ovf !== 1'b0)       begin n_fail++; $display("FAIL stream_ovf: actual %b, required 0", ovf); end
  endtask

  task automatic test_back_pressure();
    logic [OUT_W-1:0] snap;
    int b0;
    b0 = n_beats;
    out_ready = 1'b1;
    send_vec(vec_rand(), 1'b0);
    send_vec(vec_rand(), 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = vec_rand();
        mode     = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_checks += 3;
      if (out_data !== snap)  begin n_fail++; $display("FAIL bp_data_stable: actual %h, required %h", out_data, snap); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: actual %b, required 1", out_valid); end
      if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready: actual %b, required 0", in_ready); end
    end
    in_valid = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: actual %b, required 1", ovf); end
    out_ready = 1'b1;
    wait_drain(200);
    n_checks++;
    if (n_beats - b0 !== 12 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_beat_count: actual %0d, required 12", n_beats - b0);
    end
  endtask

  task automatic test_random_stalls();
    int  b0;
    int  exp_total;
    bit  sender_done;
    logic m;
    b0 = n_beats;
    exp_total = 0;
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          m = 1'($urandom_range(0, 1));
          exp_total += nb_of(m);
          send_vec(vec_rand(), m);
        end
        sender_done = 1'b1;
      end
      begin
        while (!sender_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(2000);
    n_checks += 3;
    if (exp_q.size() != 0)          begin n_fail++; $display("FAIL rand_left_over: actual %0d pending, required 0", exp_q.size()); end
    if (n_beats - b0 !== exp_total) begin n_fail++; $display("FAIL rand_beat_count: actual %0d, required %0d", n_beats - b0, exp_total); end
    if (ovf !== 1'b0)               begin n_fail++; $display("FAIL rand_ovf: actual %b, required 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_sum_extremes();
    test_streaming();
    test_back_pressure();
    apply_reset();
    test_random_stalls();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fullchip_drain.md
# fullchip_drain

Chip-level output stage for the multi-core top. It captures one psum vector per handshake from `ncore` core instances into a ping-pong (double) buffer, then drains it off-chip over a narrower valid/ready bus. In raw mode every core's psums leave unmodified. In sum mode the psums are added across cores per column first. Capture of vector N+1 overlaps the drain of vector N.

## Interface
- `col`, 8, psum columns per core
- `bw_psum`, 11, signed psum width per column
- `ncore`, 2, number of cores feeding the stage (≥1)
- `lanes`, 2, psum words per output beat; must divide `col`
- `bw_sum`, `bw_psum+$clog2(ncore)`, output lane width (localparam)

- `clk` input 1 — rising-edge clock
- `reset` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — psum vector present
- `in_ready` output 1 — write bank free
- `in_data` input `ncore*col*bw_psum` — core c, column j at bits `[(c*col+j)*bw_psum +: bw_psum]`
- `mode` input 1 — 0 raw, 1 cross-core sum; sampled with the vector
- `out_valid` output 1 — beat valid
- `out_ready` input 1 — sink accepts beat
- `out_data` output `lanes*bw_sum` — lane l at `[l*bw_sum +: bw_sum]`
- `out_last` output 1 — final beat of vector
- `ovf` output 1 — sticky: vector dropped

## Operation
- Two banks, each holding `in_data`, captured `mode` and a `full` flag.
- Pointers `wp` and `rp` are 1-bit.
- `in_ready = !full[wp]`, decoded from registers only.
- **Capture:** on `in_valid && in_ready`, write bank[wp], set `full[wp]`, toggle `wp`.
- **Drop:** `in_valid && !in_ready` drops the vector and sets `ovf`. `ovf` clears only on reset.
- **Drain FSM:** IDLE → SEND when `full[rp]`. SEND → IDLE after the last beat is loaded, unless the other bank is full; then it stays in SEND with the new `rp`.
- **Beat counter:** `beat` runs 0..NB-1. NB = `ncore*col/lanes` in mode 0, `col/lanes` in mode 1.
- **Mode 0, beat k:** lane l = sign-extend(word `k*lanes+l`) in flattened order: core 0 col 0 first, core-major.
- **Mode 1, beat k:** lane l = signed sum over c of core c, column `k*lanes+l`, at full `bw_sum`. No saturation and no overflow are possible.
- `ncore=1`: mode 1 output equals mode 0 output.
- **Output register:** loads when `!out_valid || out_ready`. `out_valid` drops when there is no beat to load and the current beat is accepted.
- Loading beat NB-1 sets `out_last`, clears `full[rp]` and toggles `rp` on the same edge.
- **Simultaneous events:**
  - Capture into `wp` and free of `rp` on the same edge touch different banks. Both take effect.
  - A freed bank raises `in_ready` only in the next cycle.
- **Reset (asynchronous, any time):** clears `full`, `wp`, `rp`, `beat`, FSM state (IDLE), `out_valid`, `out_last` and `ovf`. `out_data` resets to 0. Partly drained vectors are discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `ovf`=0.
- Handshake accepted at edge t → bank full after t → beat 0 loads at t+1. `out_valid` is high in the cycle after edge t+1.
- With `out_ready` held high, beats are back-to-back, one per cycle.
- Consecutive vectors drain with no bubble between beat NB-1 and the next beat 0.
- Sustained throughput: one vector per NB cycles. Input is never stalled while NB ≥ 2.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.

## Structure
- The shared package holds the mode encodings (`MODE_RAW`=0, `MODE_SUM`=1), the drain FSM state enum, and an `nbeats(mode)` function.
- Sub-module `psum_lane_sum`: combinational signed adder tree over `ncore` inputs for one column, instantiated `lanes` times on the selected columns.
- Bank storage uses plain flops; no memory macro is needed.

## Test plan
All scenarios use `col`=8, `bw_psum`=11, `ncore`=2, `lanes`=2, so `bw_sum`=12.
- **Reset mid-drain:**
  - Stimulus: pull `reset` low during beat 3 of a vector.
  - Required: outputs go 0 immediately and `in_ready`=1.
  - Required: after release, no beats appear until a new capture.
- **Raw mode:**
  - Stimulus: mode 0, core0 col j = j, core1 col j = -(j+1); `out_ready`=1.
  - Required: 8 beats; beat 0 = {1, 0}, beat 4 = {-2, -1} sign-extended; `out_last` on beat 7.
  - Required: first `out_valid` 2 cycles after the handshake.
- **Sum mode at extremes:**
  - Stimulus: mode 1, both cores all columns = -1024.
  - Required: 4 beats, every lane = -2048 (12'h800).
  - Stimulus: both cores all columns = 1023.
  - Required: every lane = 2046.
- **Back-pressure:**
  - Stimulus: hold `out_ready`=0 for 10 cycles mid-vector, with 2 vectors already captured.
  - Required: `out_data` stable throughout; `in_ready`=0; a third `in_valid` sets `ovf`=1.
  - Required: drained beats are unchanged by the dropped vector.
- **Streaming:**
  - Stimulus: 6 vectors with alternating modes, `in_valid` and `out_ready` always high.
  - Required: 36 beats, gapless, in order; `ovf` stays 0.
- **Random stalls:**
  - Stimulus: random `out_ready` at 50%, 100 vectors.
  - Required: scoreboard matches every beat and `out_last` position.
